// File: rtl/press_counter_ctrl.sv
// Up/down press counter: single press steps once, a held button auto-repeats after a hold delay.
// One shared timer serves both the hold delay and the repeat interval.
module press_counter_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned SATURATE      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_state,
  input  logic             up_down,
  input  logic             dn_state,
  input  logic             dn_down,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrapped
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles);
  localparam logic [TimerW-1:0] HoldLast   = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] RepeatLast = TimerW'(REPEAT_CYCLES - 1);
  localparam bit Saturate = (SATURATE != 0);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;
  typedef enum logic {DirUp, DirDn} dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              step_q, step_d;
  logic              wrapped_q, wrapped_d;

  logic apply;
  dir_e apply_dir;
  logic active_held;
  logic opp_down;

  always_comb begin
    active_held = (dir_q == DirUp) ? up_state : dn_state;
    opp_down    = (dir_q == DirUp) ? dn_down : up_down;
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    apply     = 1'b0;
    apply_dir = dir_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        // Simultaneous presses are ambiguous and therefore ignored.
        if (up_down && !dn_down) begin
          apply     = 1'b1;
          apply_dir = DirUp;
          dir_d     = DirUp;
          state_d   = StHold;
        end else if (dn_down && !up_down) begin
          apply     = 1'b1;
          apply_dir = DirDn;
          dir_d     = DirDn;
          state_d   = StHold;
        end
      end
      StHold, StRepeat: begin
        if (!active_held || opp_down) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (state_q == StHold && timer_q == HoldLast) begin
          apply   = 1'b1;
          state_d = StRepeat;
          timer_d = '0;
        end else if (state_q == StRepeat && timer_q == RepeatLast) begin
          apply   = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // A step at the range limit either wraps or, when saturating, is dropped silently.
  always_comb begin
    count_d   = count_q;
    step_d    = 1'b0;
    wrapped_d = 1'b0;
    if (apply) begin
      if (apply_dir == DirUp) begin
        if (count_q != '1) begin
          count_d = count_q + WIDTH'(1);
          step_d  = 1'b1;
        end else if (!Saturate) begin
          count_d   = '0;
          step_d    = 1'b1;
          wrapped_d = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
          step_d  = 1'b1;
        end else if (!Saturate) begin
          count_d   = '1;
          step_d    = 1'b1;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_q     <= DirUp;
      timer_q   <= '0;
      count_q   <= '0;
      step_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      step_q    <= step_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign step    = step_q;
  assign wrapped = wrapped_q;

endmodule
